pipe_stage_slice: RTL and testbench

// - Parametrised pipeline stage register, successor to the fixed-field stall-only stage registers (ID/EX, EX/MEM, MEM/WB).
// - Carries one packed payload (control field + data field) with a valid/ready handshake and a 2-entry skid buffer, so ready_o is registered.
// - Also provides a synchronous flush that squashes control bits, and a saturating stall-cycle counter for CGRA/pipeline profiling.
// - Sits between any two core stages, or between the core and the CGRA issue port.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_slot.sv | 60 ++++++
 rtl/pipe_stage_slice.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_slice.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and control-field bit positions for pipeline slices.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Occupancy state, encoded as {S.v, M.v}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        HALF  = 2'b01,
        FULL  = 2'b11
    } slice_state_e;

    // EX/MEM control field bit positions
    localparam int CTRL_REGWR   = 0;
    localparam int CTRL_MEM2REG = 1;
    localparam int CTRL_MEMRD   = 2;
    localparam int CTRL_MEMWR   = 3;
    localparam int CTRL_ZERO    = 4;

    function automatic slice_state_e slice_state(input logic s_v, input logic m_v);
        if (s_v && m_v) begin
            return FULL;
        end else if (m_v) begin
            return HALF;
        end
        return EMPTY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module : pipe_slot
// Brief  : One {v, ctrl, data} pipeline entry with load and clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_slot #(
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              v_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              v_q,    v_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Clear squashes the control bits but leaves data untouched.
    always_comb begin
        v_d    = v_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr_i) begin
            v_d    = 1'b0;
            ctrl_d = '0;
        end else if (load_i) begin
            v_d    = 1'b1;
            ctrl_d = ctrl_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q    <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q;
    assign ctrl_o = ctrl_q;
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_slice.sv
// ============================================================================
// Module : pipe_stage_slice
// Brief  : Valid/ready pipeline stage with optional skid entry, flush and a
//          saturating stall-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic              w_acc, w_pop;
    slice_state_e      w_state;

    logic              w_m_load, w_m_clr, w_m_v;
    logic [CTRL_W-1:0] w_m_ctrl_in, w_m_ctrl;
    logic [DATA_W-1:0] w_m_data_in, w_m_data;

    logic              w_s_load, w_s_clr, w_s_v;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign w_acc   = valid_i & ready_o;
    assign w_pop   = w_m_v & ready_i;
    assign w_state = slice_state(w_s_v, w_m_v);

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_m (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_m_load),
        .clr_i  (w_m_clr),
        .ctrl_i (w_m_ctrl_in),
        .data_i (w_m_data_in),
        .v_o    (w_m_v),
        .ctrl_o (w_m_ctrl),
        .data_o (w_m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_s (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load_i (w_s_load),
                .clr_i  (w_s_clr),
                .ctrl_i (ctrl_i),
                .data_i (data_i),
                .v_o    (w_s_v),
                .ctrl_o (w_s_ctrl),
                .data_o (w_s_data)
            );
            assign ready_o = ~w_s_v;
        end else begin : g_no_skid
            logic w_unused_s;
            assign w_s_v      = 1'b0;
            assign w_s_ctrl   = '0;
            assign w_s_data   = '0;
            assign w_unused_s = w_s_load ^ w_s_clr;
            assign ready_o    = ~w_m_v | ready_i;
        end
    endgenerate

    // Flush wins over any transfer; an accepted input in that cycle is dropped.
    always_comb begin
        w_m_load    = 1'b0;
        w_m_clr     = 1'b0;
        w_s_load    = 1'b0;
        w_s_clr     = 1'b0;
        w_m_ctrl_in = ctrl_i;
        w_m_data_in = data_i;
        if (flush_i) begin
            w_m_clr = 1'b1;
            w_s_clr = 1'b1;
        end else begin
            unique case (w_state)
                EMPTY: begin
                    w_m_load = w_acc;
                end
                HALF: begin
                    if (w_acc && w_pop) begin
                        w_m_load = 1'b1;
                    end else if (w_acc) begin
                        w_s_load = 1'b1;
                    end else if (w_pop) begin
                        w_m_clr = 1'b1;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_m_load    = 1'b1;
                        w_m_ctrl_in = w_s_ctrl;
                        w_m_data_in = w_s_data;
                        w_s_clr     = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_m_v && !ready_i && (stall_cnt_q != C_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = w_m_v;
    assign ctrl_o      = w_m_v ? w_m_ctrl : '0;
    assign data_o      = w_m_data;
    assign stall_cnt_o = stall_cnt_q;

    // Upstream must hold a refused payload steady; a flush releases it.
    property p_upstream_hold;
        @(posedge clk_i) disable iff (rst_i)
            (valid_i && !ready_o && !flush_i) |=> (valid_i && $stable(ctrl_i) && $stable(data_i));
    endproperty
    a_upstream_hold: assert property (p_upstream_hold);

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_slice.sv
// ============================================================================
// Module : tb_pipe_stage_slice
// Brief  : Self-checking bench for pipe_stage_slice (skid and no-skid builds)
//          against a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_slice;

    typedef struct packed {
        logic [4:0]  c;
        logic [31:0] d;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst, flush, valid, sel, ready_i;
    logic [4:0]  ctrl_in;
    logic [31:0] data_in;

    logic        a_valid_i, b_valid_i;
    logic        a_ready_o, a_valid_o, b_ready_o, b_valid_o;
    logic [4:0]  a_ctrl_o, b_ctrl_o;
    logic [31:0] a_data_o, b_data_o;
    logic [3:0]  a_cnt_o;
    logic [15:0] b_cnt_o;

    int          n_cmp  = 0;
    int          n_fail = 0;

    entry_t      qa[$];
    entry_t      qb[$];
    int          cnta, cntb;
    logic [31:0] lasta, lastb;
    bit          known    = 0;
    bit          last_acc = 0;

    always #5 clk = ~clk;

    assign a_valid_i = valid & ~sel;
    assign b_valid_i = valid & sel;

    pipe_stage_slice #(.DATA_W(32), .CTRL_W(5), .SKID(1), .CNT_W(4)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .valid_i     (a_valid_i),
        .ready_o     (a_ready_o),
        .ctrl_i      (ctrl_in),
        .data_i      (data_in),
        .valid_o     (a_valid_o),
        .ready_i     (ready_i),
        .ctrl_o      (a_ctrl_o),
        .data_o      (a_data_o),
        .stall_cnt_o (a_cnt_o)
    );

    pipe_stage_slice #(.DATA_W(32), .CTRL_W(5), .SKID(0), .CNT_W(16)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .valid_i     (b_valid_i),
        .ready_o     (b_ready_o),
        .ctrl_i      (ctrl_in),
        .data_i      (data_in),
        .valid_o     (b_valid_o),
        .ready_i     (ready_i),
        .ctrl_o      (b_ctrl_o),
        .data_o      (b_data_o),
        .stall_cnt_o (b_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after.
    task automatic tick();
        bit     ra, rb, acca, accb, popa, popb;
        entry_t e;
        #1;
        ra = (qa.size() < 2);
        rb = (qb.size() == 0) || ready_i;
        if (known) begin
            chk("a_ready", {63'd0, a_ready_o}, {63'd0, ra});
            chk("b_ready", {63'd0, b_ready_o}, {63'd0, rb});
        end
        acca     = a_valid_i && ra;
        accb     = b_valid_i && rb;
        popa     = (qa.size() != 0) && ready_i;
        popb     = (qb.size() != 0) && ready_i;
        last_acc = sel ? (valid && b_ready_o) : (valid && a_ready_o);
        e        = '{c: ctrl_in, d: data_in};
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete();
            cnta = 0; cntb = 0; lasta = '0; lastb = '0;
            known = 1;
        end else begin
            if (qa.size() != 0 && !ready_i && cnta < 15)    cnta++;
            if (qb.size() != 0 && !ready_i && cntb < 65535) cntb++;
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                if (popa) void'(qa.pop_front());
                if (acca) qa.push_back(e);
                if (popb) void'(qb.pop_front());
                if (accb) qb.push_back(e);
            end
            if (qa.size() != 0) lasta = qa[0].d;
            if (qb.size() != 0) lastb = qb[0].d;
        end
        @(negedge clk);
        if (known) begin
            chk("a_valid", {63'd0, a_valid_o}, {63'd0, qa.size() != 0});
            chk("a_ctrl",  {59'd0, a_ctrl_o},  {59'd0, (qa.size() != 0) ? qa[0].c : 5'd0});
            chk("a_data",  {32'd0, a_data_o},  {32'd0, lasta});
            chk("a_cnt",   {60'd0, a_cnt_o},   64'(cnta));
            chk("b_valid", {63'd0, b_valid_o}, {63'd0, qb.size() != 0});
            chk("b_ctrl",  {59'd0, b_ctrl_o},  {59'd0, (qb.size() != 0) ? qb[0].c : 5'd0});
            chk("b_data",  {32'd0, b_data_o},  {32'd0, lastb});
            chk("b_cnt",   {48'd0, b_cnt_o},   64'(cntb));
        end
    endtask

    task automatic push(input logic [4:0] c, input logic [31:0] d);
        valid   = 1'b1;
        ctrl_in = c;
        data_in = d;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (last_acc) return;
        end
        chk("push_timeout", {63'd0, last_acc}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_phase(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            if (!valid || last_acc) begin
                valid   = ($urandom_range(0, 3) != 0);
                ctrl_in = 5'($urandom_range(0, 31));
                data_in = $urandom;
            end
            ready_i = toggle ? i[0] : ($urandom_range(0, 9) < 7);
            flush   = !toggle && ($urandom_range(0, 31) == 0);
            rst     = !toggle && ($urandom_range(0, 127) == 0);
            tick();
        end
        flush   = 1'b0;
        rst     = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (!valid || last_acc) break;
            tick();
        end
        chk("drain_acc", {63'd0, !valid || last_acc}, 64'd1);
        valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid = 1'b1; sel = 1'b0; ready_i = 1'b1;
        ctrl_in = 5'h1f; data_in = 32'hdead_beef;

        // Reset held two cycles with valid asserted
        tick(); tick();
        chk("rst_valid", {63'd0, a_valid_o}, 64'd0);
        chk("rst_ctrl",  {59'd0, a_ctrl_o},  64'd0);
        chk("rst_data",  {32'd0, a_data_o},  64'd0);
        chk("rst_cnt",   {60'd0, a_cnt_o},   64'd0);
        rst = 1'b0; valid = 1'b0;
        #1 chk("rst_ready", {63'd0, a_ready_o}, 64'd1);
        tick();

        // Back-to-back streaming
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) push(5'(i), 32'(i));
        valid = 1'b0;
        repeat (3) tick();

        // Backpressure: A, B fill the slice, C waits upstream
        do_reset();
        ready_i = 1'b0;
        push(5'h03, 32'h0000_000a);
        push(5'h05, 32'h0000_000b);
        valid = 1'b1; ctrl_in = 5'h07; data_in = 32'h0000_000c;
        repeat (3) begin
            tick();
            chk("c_held", {63'd0, last_acc}, 64'd0);
        end
        ready_i = 1'b1;
        push(5'h07, 32'h0000_000c);
        valid = 1'b0;
        repeat (4) tick();

        // Flush while FULL, with a payload offered at the same time
        do_reset();
        ready_i = 1'b0;
        push(5'b01111, 32'h11);
        push(5'b01111, 32'h22);
        valid = 1'b1; ctrl_in = 5'b01111; data_in = 32'h33; flush = 1'b1;
        tick();
        flush = 1'b0; valid = 1'b0;
        chk("flush_valid", {63'd0, a_valid_o}, 64'd0);
        chk("flush_ctrl",  {59'd0, a_ctrl_o},  64'd0);
        ready_i = 1'b1;
        repeat (3) tick();

        // Flush in HALF consumes the offered payload and drops it
        ready_i = 1'b0;
        push(5'h1e, 32'h44);
        valid = 1'b1; ctrl_in = 5'h1d; data_in = 32'h55; flush = 1'b1;
        tick();
        chk("flush_acc", {63'd0, last_acc}, 64'd1);
        flush = 1'b0; valid = 1'b0; ready_i = 1'b1;
        repeat (3) tick();

        // Counter saturation at 15
        do_reset();
        ready_i = 1'b0;
        push(5'h01, 32'h66);
        valid = 1'b0;
        repeat (20) tick();
        chk("sat_cnt", {60'd0, a_cnt_o}, 64'd15);
        ready_i = 1'b1;
        repeat (2) tick();

        // Randomized traffic on the skid build
        do_reset();
        rand_phase(300, 1'b0);

        // No-skid build: combinational ready and toggled backpressure
        sel = 1'b1;
        do_reset();
        ready_i = 1'b0;
        push(5'h02, 32'h77);
        valid = 1'b1; ctrl_in = 5'h04; data_in = 32'h88;
        #1 chk("b_ready_stall", {63'd0, b_ready_o}, 64'd0);
        ready_i = 1'b1;
        push(5'h04, 32'h88);
        valid = 1'b0;
        tick();
        rand_phase(60, 1'b1);
        rand_phase(200, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
